field_extract_sequencer: RTL

//   Runtime-programmable header-field extractor for the SDN match path. Accepts one packet word,

---
 rtl/field_extract_sequencer_pkg.sv | 21 ++
 rtl/field_extract_sequencer_if.sv | 41 ++++
 rtl/field_extract_sequencer_field_slice.sv | 29 ++
 rtl/field_extract_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/field_extract_sequencer_pkg.sv
// Shared types and default widths for the header-field extractor and the match stage.
package field_extract_sequencer_pkg;

    localparam int PKT_W_DEF      = 256;
    localparam int FIELD_W_DEF    = 32;
    localparam int NUM_FIELDS_DEF = 4;
    localparam int IDX_W_DEF      = $clog2(PKT_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default-width table entry, as seen by the control plane and the match stage.
    typedef struct packed {
        logic [IDX_W_DEF-1:0] start_idx;
        logic [IDX_W_DEF-1:0] end_idx;
    } field_cfg_t;

endpackage

// File: rtl/field_extract_sequencer_if.sv
// Packet-in, config and field-out signals of the extractor; slave = extractor side.
interface field_extract_sequencer_if
    import field_extract_sequencer_pkg::*;
#(
    parameter int PKT_W      = PKT_W_DEF,
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int NUM_FIELDS = NUM_FIELDS_DEF
);
    localparam int IDX_W = $clog2(PKT_W);
    localparam int FID_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic               pkt_valid;
    logic               pkt_ready;
    logic [PKT_W-1:0]   pkt_data;
    logic               cfg_we;
    logic [FID_W-1:0]   cfg_idx;
    logic [IDX_W-1:0]   cfg_start;
    logic [IDX_W-1:0]   cfg_end;
    logic               cfg_num_we;
    logic [FID_W:0]     cfg_num;
    logic               fld_valid;
    logic               fld_ready;
    logic [FIELD_W-1:0] fld_data;
    logic [FID_W-1:0]   fld_id;
    logic               fld_last;
    logic               fld_err;
    logic               pkt_done;

    modport master (
        output pkt_valid, pkt_data, cfg_we, cfg_idx, cfg_start, cfg_end,
               cfg_num_we, cfg_num, fld_ready,
        input  pkt_ready, fld_valid, fld_data, fld_id, fld_last, fld_err, pkt_done
    );

    modport slave (
        input  pkt_valid, pkt_data, cfg_we, cfg_idx, cfg_start, cfg_end,
               cfg_num_we, cfg_num, fld_ready,
        output pkt_ready, fld_valid, fld_data, fld_id, fld_last, fld_err, pkt_done
    );

endinterface

// File: rtl/field_extract_sequencer_field_slice.sv
// Combinational runtime-offset slicer: data = pkt[end:start], LSB-aligned and zero-extended.
// Reversed or over-wide ranges flag err and force data to zero.
module field_extract_sequencer_field_slice #(
    parameter int PKT_W   = 256,
    parameter int FIELD_W = 32,
    parameter int IDX_W   = 8
) (
    input  logic [PKT_W-1:0]   pkt_i,
    input  logic [IDX_W-1:0]   start_i,
    input  logic [IDX_W-1:0]   end_i,
    output logic [FIELD_W-1:0] data_o,
    output logic               err_o
);
    localparam logic [IDX_W-1:0] FW_M1 = IDX_W'(FIELD_W - 1);

    logic [FIELD_W-1:0] low;
    logic [FIELD_W-1:0] mask;
    logic [IDX_W-1:0]   span;

    always_comb begin
        low    = FIELD_W'(pkt_i >> start_i);
        span   = end_i - start_i;
        err_o  = (end_i < start_i) || (span > FW_M1);
        // span+1 ones at the bottom; only meaningful when the range is legal
        mask   = {FIELD_W{1'b1}} >> (FW_M1 - span);
        data_o = err_o ? '0 : (low & mask);
    end

endmodule

// File: rtl/field_extract_sequencer.sv
// Programmable field extractor: accept one packet word, emit up to NUM_FIELDS slices in table order.
// First field one cycle after accept, then 1 field/cycle; outputs hold while fld_ready is low.
module field_extract_sequencer
    import field_extract_sequencer_pkg::*;
#(
    parameter int PKT_W      = PKT_W_DEF,
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int NUM_FIELDS = NUM_FIELDS_DEF
) (
    input logic                      clk,
    input logic                      rst,
    field_extract_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(PKT_W);
    localparam int FID_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [FID_W:0] NUM_C = (FID_W + 1)'(NUM_FIELDS);

    typedef struct packed {
        logic [IDX_W-1:0] start_idx;
        logic [IDX_W-1:0] end_idx;
    } ent_t;

    ent_t               live_q [NUM_FIELDS];
    ent_t               shd_q  [NUM_FIELDS];
    logic [FID_W:0]     num_q, shd_num_q;
    logic [PKT_W-1:0]   pkt_q;

    state_t             state_q, state_d;
    logic [FID_W-1:0]   idx_q, idx_d;
    logic               accept;
    logic               vld_q, vld_d, last_q, last_d, err_q, err_d;
    logic [FIELD_W-1:0] dat_q, dat_d;
    logic [FID_W-1:0]   id_q, id_d;
    logic               rdy_q, done_q;

    ent_t               cur_ent;
    logic [FIELD_W-1:0] slice_dat;
    logic               slice_err;

    assign cur_ent = shd_q[idx_q];

    field_extract_sequencer_field_slice #(
        .PKT_W   (PKT_W),
        .FIELD_W (FIELD_W),
        .IDX_W   (IDX_W)
    ) u_slice (
        .pkt_i   (pkt_q),
        .start_i (cur_ent.start_idx),
        .end_i   (cur_ent.end_idx),
        .data_o  (slice_dat),
        .err_o   (slice_err)
    );

    // Live table: control-plane view, never read directly by the emit path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                live_q[i] <= '{start_idx: '0, end_idx: IDX_W'(FIELD_W - 1)};
            end
            num_q <= NUM_C;
        end else begin
            if (bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM_C)) begin
                live_q[bus.cfg_idx] <= '{start_idx: bus.cfg_start, end_idx: bus.cfg_end};
            end
            if (bus.cfg_num_we) begin
                num_q <= (bus.cfg_num > NUM_C) ? NUM_C : bus.cfg_num;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q     <= '0;
            shd_num_q <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shd_q[i] <= '0;
            end
        end else if (accept) begin
            pkt_q     <= bus.pkt_data;
            shd_q     <= live_q;
            shd_num_q <= num_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        vld_d   = vld_q;
        dat_d   = dat_q;
        id_d    = id_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.pkt_valid && rdy_q) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = (num_q == '0) ? ST_DONE : ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (vld_q && bus.fld_ready && last_q) begin
                    state_d = ST_DONE;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (!vld_q || bus.fld_ready) begin
                    // idx_q always points at the next field to load into the output register
                    vld_d  = 1'b1;
                    dat_d  = slice_dat;
                    err_d  = slice_err;
                    id_d   = idx_q;
                    last_d = ({1'b0, idx_q} == (shd_num_q - 1'b1));
                    idx_d  = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            id_q    <= id_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rdy_q   <= (state_d == ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.pkt_ready = rdy_q;
    assign bus.fld_valid = vld_q;
    assign bus.fld_data  = dat_q;
    assign bus.fld_id    = id_q;
    assign bus.fld_last  = last_q;
    assign bus.fld_err   = err_q;
    assign bus.pkt_done  = done_q;

endmodule
